// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline constants: status codes, NOP/RNONE encodings,
// field widths and the exception classifier used by the stage registers.
package y86_pkg;

  localparam int VAL_W   = 64;
  localparam int REG_W   = 4;
  localparam int STAT_W  = 3;
  localparam int ICODE_W = 4;

  localparam logic [STAT_W-1:0] STAT_BUB = 3'd0;
  localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
  localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
  localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
  localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

  localparam logic [ICODE_W-1:0] I_NOP = 4'h1;
  localparam logic [REG_W-1:0]   RNONE = 4'hF;

  // What a stage register does at the next rising edge, in priority order.
  typedef enum logic [1:0] {
    ACT_RST    = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_LOAD   = 2'd3
  } stage_act_e;

  // Codes 5..7 are carried through untouched and never count as exceptions.
  function automatic logic is_exc(input logic [STAT_W-1:0] stat);
    logic exc;
    case (stat)
      STAT_HLT, STAT_ADR, STAT_INS: exc = 1'b1;
      default:                      exc = 1'b0;
    endcase
    return exc;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;
  logic         at_max_s;

  assign at_max_s = (count_r == {W{1'b1}});

  // Count register: clears on reset, increments on inc unless already saturated.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (inc && !at_max_s) begin
      count_r <= count_r + W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic Y86-64 pipeline boundary register with stall, bubble injection,
// optional freeze-on-exception, sticky control-error flag and bubble counter.
module pipe_stage_reg
  import y86_pkg::*;
#(
  parameter int NUM_VAL     = 2,
  parameter int NUM_REG     = 2,
  parameter int HALT_ON_EXC = 0,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     bubble,
  input  logic [STAT_W-1:0]        in_stat,
  input  logic [ICODE_W-1:0]       in_icode,
  input  logic [NUM_VAL*VAL_W-1:0] in_val,
  input  logic [NUM_REG*REG_W-1:0] in_reg,
  output logic [STAT_W-1:0]        out_stat,
  output logic [ICODE_W-1:0]       out_icode,
  output logic [NUM_VAL*VAL_W-1:0] out_val,
  output logic [NUM_REG*REG_W-1:0] out_reg,
  output logic                     out_valid,
  output logic                     frozen,
  output logic                     ctl_err,
  output logic [CNT_W-1:0]         bubble_cnt
);

  logic [STAT_W-1:0]  stat_r;
  logic [ICODE_W-1:0] icode_r;
  logic [VAL_W-1:0]   val_r    [NUM_VAL];
  logic [REG_W-1:0]   reg_r    [NUM_REG];
  logic [VAL_W-1:0]   in_val_s [NUM_VAL];
  logic [REG_W-1:0]   in_reg_s [NUM_REG];
  logic               valid_r;
  logic               err_r;
  logic               frozen_s;
  logic               bub_inc_s;
  stage_act_e         act_s;

  genvar k;
  generate
    for (k = 0; k < NUM_VAL; k++) begin : g_val
      assign in_val_s[k]                 = in_val[k*VAL_W +: VAL_W];
      assign out_val[k*VAL_W +: VAL_W]   = val_r[k];
    end
    for (k = 0; k < NUM_REG; k++) begin : g_reg
      assign in_reg_s[k]                 = in_reg[k*REG_W +: REG_W];
      assign out_reg[k*REG_W +: REG_W]   = reg_r[k];
    end
  endgenerate

  // Freeze is decoded from the held stat, so it blocks the very next edge.
  assign frozen_s = (HALT_ON_EXC != 0) && is_exc(stat_r);

  // Edge action selection: rst > frozen > stall > bubble > load.
  always_comb begin
    act_s = ACT_LOAD;
    if (rst) begin
      act_s = ACT_RST;
    end else if (frozen_s || stall) begin
      act_s = ACT_HOLD;
    end else if (bubble) begin
      act_s = ACT_BUBBLE;
    end else begin
      act_s = ACT_LOAD;
    end
  end

  assign bub_inc_s = (act_s == ACT_BUBBLE);

  // Payload registers: bubble payload on reset/bubble, inputs on load, else hold.
  always_ff @(posedge clk) begin
    case (act_s)
      ACT_RST, ACT_BUBBLE: begin
        stat_r  <= STAT_BUB;
        icode_r <= I_NOP;
        valid_r <= 1'b0;
        for (int i = 0; i < NUM_VAL; i++) val_r[i] <= {VAL_W{1'b0}};
        for (int i = 0; i < NUM_REG; i++) reg_r[i] <= RNONE;
      end
      ACT_LOAD: begin
        stat_r  <= in_stat;
        icode_r <= in_icode;
        valid_r <= 1'b1;
        for (int i = 0; i < NUM_VAL; i++) val_r[i] <= in_val_s[i];
        for (int i = 0; i < NUM_REG; i++) reg_r[i] <= in_reg_s[i];
      end
      default: begin
        stat_r  <= stat_r;
        icode_r <= icode_r;
        valid_r <= valid_r;
        for (int i = 0; i < NUM_VAL; i++) val_r[i] <= val_r[i];
        for (int i = 0; i < NUM_REG; i++) reg_r[i] <= reg_r[i];
      end
    endcase
  end

  // Sticky control error: conflicting stall+bubble is recorded even while frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (stall && bubble) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bub_inc_s),
    .count (bubble_cnt)
  );

  assign out_stat  = stat_r;
  assign out_icode = icode_r;
  assign out_valid = valid_r;
  assign frozen    = frozen_s;
  assign ctl_err   = err_r;

endmodule
